msg_scroll_counter: RTL and testbench



---
 rtl/msg_scroll_counter.sv | 97 +++++++++
 tb/tb_msg_scroll_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/msg_scroll_counter.sv
// Scroll-window address generator: a debounced button press or an auto tick moves the base pointer by one.
// NUM_DIGITS addresses (base+k) mod MSG_LEN are registered alongside base, and a one-cycle pulse flags each move.
`timescale 1ns/1ps
module msg_scroll_counter #(
  parameter int ADDR_W          = 4,
  parameter int NUM_DIGITS      = 4,
  parameter int MSG_LEN         = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_PERIOD     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         button,
  input  logic                         dir,
  input  logic                         auto_en,
  output logic [NUM_DIGITS*ADDR_W-1:0] adr_bus,
  output logic [ADDR_W-1:0]            base,
  output logic                         shift_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_W = $clog2(AUTO_PERIOD);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(MSG_LEN - 1);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_X  = (ADDR_W+1)'(MSG_LEN);
  localparam logic [CNT_W-1:0]  DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_1  = CNT_W'(1);
  localparam logic [TMR_W-1:0]  TMR_MAX = TMR_W'(AUTO_PERIOD - 1);
  localparam logic [TMR_W-1:0]  TMR_1  = TMR_W'(1);

  logic              sync1, s, db, db_q, step_man;
  logic [CNT_W-1:0]  db_cnt;
  logic [TMR_W-1:0]  timer;
  logic              auto_tick, step;
  logic [ADDR_W-1:0] base_next;

  // Addresses never exceed 2*MSG_LEN-2, so a single conditional subtract wraps them.
  function automatic logic [NUM_DIGITS*ADDR_W-1:0] window(input logic [ADDR_W-1:0] b);
    logic [ADDR_W:0] sum;
    window = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      sum = {1'b0, b} + (ADDR_W+1)'(k);
      if (sum >= LEN_X) sum = sum - LEN_X;
      window[k*ADDR_W +: ADDR_W] = sum[ADDR_W-1:0];
    end
  endfunction

  assign auto_tick = auto_en && (timer == TMR_MAX);
  assign step      = step_man || auto_tick;

  always_comb begin
    base_next = base;
    if (step) begin
      if (dir) base_next = (base == '0)  ? LAST : base - ONE;
      else     base_next = (base == LAST) ? '0  : base + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= 1'b0;
      s           <= 1'b0;
      db          <= 1'b0;
      db_q        <= 1'b0;
      db_cnt      <= '0;
      step_man    <= 1'b0;
      timer       <= '0;
      base        <= '0;
      adr_bus     <= window('0);
      shift_pulse <= 1'b0;
    end else begin
      sync1 <= button;
      s     <= sync1;

      if (s == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        db     <= s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_1;
      end

      // Rising edge of the debounced level is registered, giving one step per press.
      db_q     <= db;
      step_man <= db & ~db_q;

      if (!auto_en || step) timer <= '0;
      else                  timer <= timer + TMR_1;

      base        <= base_next;
      adr_bus     <= window(base_next);
      shift_pulse <= step;
    end
  end

endmodule

// File: tb/tb_msg_scroll_counter.sv
// Bench for msg_scroll_counter: directed button/auto stimulus, a cycle-level reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
`timescale 1ns/1ps
module tb_msg_scroll_counter;
  localparam int ADDR_W = 4, NUM_DIGITS = 4, MSG_LEN = 16, DEB = 4, PER = 8;
  localparam int HL = DEB + 2;

  logic clk = 1'b0, reset = 1'b0, button = 1'b0, dir = 1'b0, auto_en = 1'b0;
  logic [NUM_DIGITS*ADDR_W-1:0] adr_bus;
  logic [ADDR_W-1:0] base;
  logic shift_pulse;

  msg_scroll_counter #(.ADDR_W(ADDR_W), .NUM_DIGITS(NUM_DIGITS), .MSG_LEN(MSG_LEN),
                       .DEBOUNCE_CYCLES(DEB), .AUTO_PERIOD(PER)) dut (
    .clk(clk), .reset(reset), .button(button), .dir(dir), .auto_en(auto_en),
    .adr_bus(adr_bus), .base(base), .shift_pulse(shift_pulse));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0, pulses = 0;
  int plog[$];
  bit started = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: button sample history, accepted level, scheduled manual steps, auto anchor.
  bit hist [HL];
  bit m_db, m_pulse;
  int m_base, anchor;
  int mq[$];

  function automatic logic [63:0] exp_adr(input int b);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < NUM_DIGITS; k++) r[k*ADDR_W +: ADDR_W] = ADDR_W'((b + k) % MSG_LEN);
    return r;
  endfunction

  always @(posedge clk) begin
    bit flip, man, aut;
    cyc++;
    if (reset) begin
      for (int i = 0; i < HL; i++) hist[i] = 1'b0;
      m_db = 0; m_pulse = 0; m_base = 0; anchor = cyc; mq.delete(); started = 1;
    end else begin
      for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = button;
      // Accept when the synchronised input (two edges old) disagreed for DEB consecutive edges.
      flip = 1;
      for (int i = 2; i <= DEB + 1; i++) if (hist[i] == m_db) flip = 0;
      if (flip) begin
        m_db = !m_db;
        if (m_db) mq.push_back(cyc + 2);
      end
      man = (mq.size() > 0) && (mq[0] == cyc);
      if (man) void'(mq.pop_front());
      aut = auto_en && (cyc - anchor == PER);
      if (man || aut) m_base = dir ? (m_base + MSG_LEN - 1) % MSG_LEN : (m_base + 1) % MSG_LEN;
      m_pulse = man || aut;
      if (man || aut || !auto_en) anchor = cyc;
    end
  end

  always @(posedge clk) begin
    #1;
    if (started) begin
      chk("model_base", 64'(base), 64'(m_base));
      chk("model_adr", 64'(adr_bus), exp_adr(m_base));
      chk("model_pulse", 64'(shift_pulse), 64'(m_pulse));
      if (shift_pulse) begin
        pulses++;
        plog.push_back(cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1; button = 0;
    tick(n);
    reset = 0;
  endtask

  task automatic press(input int hold, input int rel);
    button = 1;
    tick(hold);
    button = 0;
    tick(rel);
  endtask

  initial begin
    int c, p0, r;
    int exp_q[$];

    // Reset defaults
    do_reset(2);
    chk("rst_base", 64'(base), 64'h0);
    chk("rst_adr", 64'(adr_bus), 64'h3210);
    chk("rst_pulse", 64'(shift_pulse), 64'h0);

    // Single press held 20 cycles
    c = cyc; p0 = pulses; plog.delete();
    press(20, 20);
    chk("single_pulses", 64'(pulses - p0), 64'd1);
    chk("single_when", 64'(plog.size() > 0 ? plog[0] : -1), 64'(c + 1 + 7));
    chk("single_base", 64'(base), 64'h1);
    chk("single_adr", 64'(adr_bus), 64'h4321);

    // Glitches shorter than the debounce window
    do_reset(2);
    p0 = pulses;
    for (int i = 0; i < 5; i++) press(3, 10);
    chk("glitch_pulses", 64'(pulses - p0), 64'd0);
    chk("glitch_base", 64'(base), 64'h0);

    // Forward wrap to 15, then one backward step
    for (int i = 0; i < 15; i++) press(10, 10);
    chk("fwd15_base", 64'(base), 64'hF);
    chk("fwd15_adr", 64'(adr_bus), 64'h210F);
    dir = 1;
    press(10, 10);
    chk("back_base", 64'(base), 64'hE);
    chk("back_adr", 64'(adr_bus), 64'h10FE);
    do_reset(2);
    press(10, 10);
    chk("back0_base", 64'(base), 64'hF);
    chk("back0_adr", 64'(adr_bus), 64'h210F);
    dir = 0;

    // Auto scroll for 40 cycles
    do_reset(2);
    p0 = pulses;
    auto_en = 1;
    tick(40);
    auto_en = 0;
    tick(2);
    chk("auto_pulses", 64'(pulses - p0), 64'd5);
    chk("auto_base", 64'(base), 64'h5);

    // Manual press mid-period restarts the auto spacing
    do_reset(2);
    r = cyc; plog.delete();
    auto_en = 1;
    tick(4);
    press(10, 16);
    auto_en = 0;
    exp_q = '{r + 8, r + 12, r + 20, r + 28};
    chk("mid_count", 64'(plog.size()), 64'd4);
    for (int i = 0; i < plog.size() && i < 4; i++) chk("mid_cycle", 64'(plog[i]), 64'(exp_q[i]));
    chk("mid_base", 64'(base), 64'h4);

    // Manual step coinciding with an auto tick yields a single step
    do_reset(2);
    r = cyc; plog.delete();
    auto_en = 1;
    press(10, 8);
    auto_en = 0;
    tick(2);
    chk("sim_count", 64'(plog.size()), 64'd2);
    chk("sim_first", 64'(plog.size() > 0 ? plog[0] : -1), 64'(r + 8));
    chk("sim_base", 64'(base), 64'h2);

    // Reset before the press is accepted discards it
    do_reset(2);
    p0 = pulses;
    button = 1;
    tick(5);
    reset = 1; button = 0;
    tick(2);
    reset = 0;
    tick(20);
    chk("rstmid_pulses", 64'(pulses - p0), 64'd0);
    chk("rstmid_base", 64'(base), 64'h0);
    press(10, 10);
    chk("rstmid_after", 64'(base), 64'h1);
    chk("rstmid_adr", 64'(adr_bus), 64'h4321);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
